// File: rtl/serial_adder_arbiter.sv
// serial_adder_arbiter: round-robin front end for one shared bit-serial adder.
// A granted operand pair is added LSB-first over WORDWIDTH cycles. The sum,
// carry and requester ID are then held on a response channel until accepted.
module serial_adder_arbiter #(
  parameter  int WORDWIDTH = 8,
  parameter  int NUM_REQ   = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORDWIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WORDWIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WORDWIDTH-1:0]           rsp_sum,
  output logic                           rsp_cout,
  output logic [IDW-1:0]                 rsp_id,
  output logic                           busy
);

  localparam int CW = $clog2(WORDWIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]           state_q,   state_d;
  logic [IDW-1:0]       ptr_q,     ptr_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic                 carry_q,   carry_d;
  logic [WORDWIDTH-1:0] a_sr_q,    a_sr_d;
  logic [WORDWIDTH-1:0] b_sr_q,    b_sr_d;
  logic [WORDWIDTH-1:0] sum_sr_q,  sum_sr_d;
  logic [IDW-1:0]       id_q,      id_d;
  logic [WORDWIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic                 rsp_cout_q, rsp_cout_d;
  logic [IDW-1:0]       rsp_id_q,  rsp_id_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic [WORDWIDTH-1:0] op_a [NUM_REQ];
  logic [WORDWIDTH-1:0] op_b [NUM_REQ];
  logic                 grant_found;
  logic [IDW-1:0]       grant_id;
  logic [IDW-1:0]       cand;
  logic                 fa_s;
  logic                 fa_c;
  logic                 in_idle;

  assign in_idle = (state_q == ST_IDLE);

  // Unpack operands and form the one-hot grant. The grant is held low while
  // reset is asserted so no requester sees a handshake during reset.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_a[gi]      = req_a[gi*WORDWIDTH +: WORDWIDTH];
      assign op_b[gi]      = req_b[gi*WORDWIDTH +: WORDWIDTH];
      assign req_ready[gi] = rst_n && in_idle && grant_found && (grant_id == IDW'(gi));
    end
  endgenerate

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // The single shared full adder works on the operand LSBs and the carry flop.
  assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  // Next-state logic for the IDLE -> SHIFT -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    sum_sr_d    = sum_sr_q;
    id_d        = id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          a_sr_d  = op_a[grant_id];
          b_sr_d  = op_b[grant_id];
          carry_d = 1'b0;
          cnt_d   = '0;
          id_d    = grant_id;
          ptr_d   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        carry_d  = fa_c;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WORDWIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WORDWIDTH - 1)) begin
          cnt_d       = '0;
          rsp_sum_d   = {fa_s, sum_sr_q[WORDWIDTH-1:1]};
          rsp_cout_d  = fa_c;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any add in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      id_q        <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      id_q        <= id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = !in_idle;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Directed bench for serial_adder_arbiter (WORDWIDTH=8, NUM_REQ=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_serial_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_cmp;
  int n_err;

  serial_adder_arbiter #(.WORDWIDTH(8), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
  endtask

  // Advance from a grant cycle until rsp_valid; k = cycles taken (-1 on
  // timeout), bh = cycles with busy high. Bits in clr are dropped from
  // req_valid after the grant edge.
  task automatic wait_rsp(input logic [3:0] clr, output int k, output int bh);
    k  = 0;
    bh = 0;
    do begin
      tick();
      if (k == 0) req_valid = req_valid & ~clr;
      k++;
      if (busy) bh++;
    end while (!rsp_valid && k < 40);
    if (!rsp_valid) k = -1;
    $display("rsp: k=%0d id=%0d sum=%h cout=%0d", k, rsp_id, rsp_sum, rsp_cout);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
    repeat (3) tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({rsp_sum, rsp_cout, rsp_id} !== 11'd0) begin n_err++; $display("FAIL reset_rsp: got %h/%b/%0d want 0/0/0", rsp_sum, rsp_cout, rsp_id); end
    req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int k, bh;
    set_req(0, 8'h35, 8'h4A);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    wait_rsp(4'b0001, k, bh);
    n_cmp++; if (k !== 9) begin n_err++; $display("FAIL single_latency: got %0d want 9", k); end
    n_cmp++; if (bh !== 9) begin n_err++; $display("FAIL single_busy: got %0d want 9", bh); end
    n_cmp++; if (rsp_sum !== 8'h7F) begin n_err++; $display("FAIL single_sum: got %h want 7f", rsp_sum); end
    n_cmp++; if (rsp_cout !== 1'b0) begin n_err++; $display("FAIL single_cout: got %b want 0", rsp_cout); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: got valid=%b busy=%b want 0/0", rsp_valid, busy); end
    n_cmp++; if (rsp_sum !== 8'h7F) begin n_err++; $display("FAIL single_hold: got %h want 7f", rsp_sum); end
  endtask

  task automatic test_overflow();
    int k, bh;
    set_req(2, 8'hFF, 8'h01);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ovf1_grant: got %b want 0100", req_ready); end
    wait_rsp(4'b0100, k, bh);
    n_cmp++; if (k !== 9) begin n_err++; $display("FAIL ovf1_latency: got %0d want 9", k); end
    n_cmp++; if ({rsp_sum, rsp_cout, rsp_id} !== {8'h00, 1'b1, 2'd2}) begin n_err++; $display("FAIL ovf1_rsp: got %h/%b/%0d want 00/1/2", rsp_sum, rsp_cout, rsp_id); end
    tick();
    set_req(2, 8'hC8, 8'hC8);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ovf2_grant: got %b want 0100", req_ready); end
    wait_rsp(4'b0100, k, bh);
    n_cmp++; if ({rsp_sum, rsp_cout, rsp_id} !== {8'h90, 1'b1, 2'd2}) begin n_err++; $display("FAIL ovf2_rsp: got %h/%b/%0d want 90/1/2", rsp_sum, rsp_cout, rsp_id); end
    tick();
  endtask

  // Pointer is 3 here; requester 0 wins after wrapping.
  task automatic test_operand_change();
    int k, bh;
    set_req(0, 8'h11, 8'h22);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL opchg_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    set_req(0, 8'hFF, 8'hFF);
    k = 0;
    while (!rsp_valid && k < 40) begin tick(); k++; end
    n_cmp++; if (k !== 8) begin n_err++; $display("FAIL opchg_latency: got %0d want 8", k); end
    n_cmp++; if ({rsp_sum, rsp_cout, rsp_id} !== {8'h33, 1'b0, 2'd0}) begin n_err++; $display("FAIL opchg_rsp: got %h/%b/%0d want 33/0/0", rsp_sum, rsp_cout, rsp_id); end
    $display("rsp: id=%0d sum=%h cout=%0d", rsp_id, rsp_sum, rsp_cout);
    tick();
  endtask

  // Pointer is 1: requester 1 wins, requester 3 waits through a stalled response.
  task automatic test_backpressure();
    int k, bh;
    set_req(1, 8'h12, 8'h34);
    set_req(3, 8'h0F, 8'hF2);
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
    wait_rsp(4'b0010, k, bh);
    n_cmp++; if (k !== 9) begin n_err++; $display("FAIL bp_latency: got %0d want 9", k); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46 || rsp_cout !== 1'b0 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL bp_stall%0d: got v=%b sum=%h c=%b id=%0d rdy=%b busy=%b want 1/46/0/1/0000/1", i, rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready, busy);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_grant3: got %b want 1000", req_ready); end
    n_cmp++; if (rsp_sum !== 8'h46) begin n_err++; $display("FAIL bp_hold: got %h want 46", rsp_sum); end
    wait_rsp(4'b1000, k, bh);
    n_cmp++; if ({rsp_sum, rsp_cout, rsp_id} !== {8'h01, 1'b1, 2'd3}) begin n_err++; $display("FAIL bp_rsp3: got %h/%b/%0d want 01/1/3", rsp_sum, rsp_cout, rsp_id); end
    tick();
  endtask

  // Pointer is 0; requester 2 starts, then reset lands in its 4th shift cycle.
  task automatic test_reset_mid_shift();
    int cnt_v, cnt_b;
    set_req(2, 8'hFF, 8'hFF);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst_mid_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || rsp_sum !== 8'h00 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got v=%b busy=%b rdy=%b sum=%h c=%b id=%0d want all 0", rsp_valid, busy, req_ready, rsp_sum, rsp_cout, rsp_id);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    cnt_v = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) cnt_v++;
      if (busy) cnt_b++;
    end
    n_cmp++; if (cnt_v !== 0) begin n_err++; $display("FAIL rst_mid_novalid: got %0d want 0", cnt_v); end
    n_cmp++; if (cnt_b !== 0) begin n_err++; $display("FAIL rst_mid_nobusy: got %0d want 0", cnt_b); end
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_mid_ptr: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_sum [4];
    logic       exp_cout [4];
    logic [3:0] exp_rdy;
    int k, bh, g;
    exp_sum[0] = 8'h03; exp_cout[0] = 1'b0; set_req(0, 8'h01, 8'h02);
    exp_sum[1] = 8'h00; exp_cout[1] = 1'b1; set_req(1, 8'h80, 8'h80);
    exp_sum[2] = 8'h80; exp_cout[2] = 1'b0; set_req(2, 8'h7F, 8'h01);
    exp_sum[3] = 8'hFF; exp_cout[3] = 1'b0; set_req(3, 8'hAA, 8'h55);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      exp_rdy = 4'b0001 << g;
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, exp_rdy); end
      wait_rsp(4'b0000, k, bh);
      n_cmp++; if (k !== 9) begin n_err++; $display("FAIL rr_latency%0d: got %0d want 9", n, k); end
      n_cmp++;
      if (rsp_id !== 2'(g) || rsp_sum !== exp_sum[g] || rsp_cout !== exp_cout[g]) begin
        n_err++;
        $display("FAIL rr_rsp%0d: got %0d/%h/%b want %0d/%h/%b", n, rsp_id, rsp_sum, rsp_cout, g, exp_sum[g], exp_cout[g]);
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_overflow();
    test_operand_change();
    test_backpressure();
    test_reset_mid_shift();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
